// File: rtl/hub75_scanner.sv
// HUB75 LED panel scanner: streams framebuffer rows into the panel shift chain
// and lights each row with binary-coded-modulation bit planes.
module hub75_scanner #(
    parameter int unsigned PANEL_WIDTH = 64,
    parameter int unsigned HALF_ROWS   = 16,
    parameter int unsigned PLANES      = 5,
    parameter int unsigned BASE_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [9:0]  read_addr,
    output logic        read_en,
    input  logic [15:0] read_data_top,
    input  logic [15:0] read_data_bottom,
    output logic        hub75_r1,
    output logic        hub75_g1,
    output logic        hub75_b1,
    output logic        hub75_r2,
    output logic        hub75_g2,
    output logic        hub75_b2,
    output logic        hub75_clk,
    output logic        hub75_lat,
    output logic        hub75_oe_n,
    output logic [3:0]  hub75_addr,
    output logic        frame_done
);

    localparam int unsigned COL_W = $clog2(PANEL_WIDTH);
    localparam int unsigned ROW_W = $clog2(HALF_ROWS);
    localparam int unsigned PL_W  = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(PANEL_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(HALF_ROWS - 1);
    localparam logic [PL_W-1:0]  LAST_PLANE = PL_W'(PLANES - 1);

    typedef enum logic [2:0] {
        IDLE, PREFETCH, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] row;
    logic [PL_W-1:0]  plane;
    logic [COL_W-1:0] col;
    logic [15:0]      disp_cnt;

    logic [3:0]       r_idx, g_idx, b_idx;
    logic             last_plane, last_row;
    logic [ROW_W-1:0] next_row;

    // RGB565 bit of the current plane: red from bit 11, green from bit 6, blue from bit 0
    assign r_idx = 4'd11 + 4'(plane);
    assign g_idx = 4'd6 + 4'(plane);
    assign b_idx = 4'(plane);

    assign last_plane = (plane == LAST_PLANE);
    assign last_row   = (row == LAST_ROW);
    assign next_row   = !last_plane ? row : (last_row ? '0 : row + ROW_W'(1));

    // Outputs are loaded on the edge entering the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            row        <= '0;
            plane      <= '0;
            col        <= '0;
            disp_cnt   <= '0;
            read_addr  <= '0;
            read_en    <= 1'b0;
            hub75_r1   <= 1'b0;
            hub75_g1   <= 1'b0;
            hub75_b1   <= 1'b0;
            hub75_r2   <= 1'b0;
            hub75_g2   <= 1'b0;
            hub75_b2   <= 1'b0;
            hub75_clk  <= 1'b0;
            hub75_lat  <= 1'b0;
            hub75_oe_n <= 1'b1;
            hub75_addr <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= PREFETCH;
                        row       <= '0;
                        plane     <= '0;
                        col       <= '0;
                        read_en   <= 1'b1;
                        read_addr <= '0;
                    end
                end
                PREFETCH: begin
                    state <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    hub75_r1  <= read_data_top[r_idx];
                    hub75_g1  <= read_data_top[g_idx];
                    hub75_b1  <= read_data_top[b_idx];
                    hub75_r2  <= read_data_bottom[r_idx];
                    hub75_g2  <= read_data_bottom[g_idx];
                    hub75_b2  <= read_data_bottom[b_idx];
                    hub75_clk <= 1'b1;
                    state     <= SHIFT_HI;
                    // Next pixel's address goes out during the high phase
                    if (col != LAST_COL) begin
                        read_addr <= 10'({row, col + COL_W'(1)});
                    end
                end
                SHIFT_HI: begin
                    hub75_clk <= 1'b0;
                    if (col != LAST_COL) begin
                        col   <= col + COL_W'(1);
                        state <= SHIFT_LO;
                    end else begin
                        read_en <= 1'b0;
                        state   <= BLANK;
                    end
                end
                BLANK: begin
                    hub75_addr <= 4'(row);
                    hub75_lat  <= 1'b1;
                    state      <= LATCH;
                end
                LATCH: begin
                    hub75_lat  <= 1'b0;
                    hub75_oe_n <= 1'b0;
                    disp_cnt   <= (16'(BASE_CYCLES) << plane) - 16'd1;
                    state      <= DISPLAY;
                end
                DISPLAY: begin
                    if (disp_cnt != 16'd0) begin
                        disp_cnt <= disp_cnt - 16'd1;
                    end else begin
                        hub75_oe_n <= 1'b1;
                        col        <= '0;
                        frame_done <= last_plane && last_row;
                        if (enable) begin
                            state     <= PREFETCH;
                            row       <= next_row;
                            plane     <= last_plane ? '0 : plane + PL_W'(1);
                            read_en   <= 1'b1;
                            read_addr <= 10'({next_row, COL_W'(0)});
                        end else begin
                            state <= IDLE;
                            row   <= '0;
                            plane <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scanner.sv
// Directed bench for hub75_scanner: shift, BCM timing, addressing, frame cadence,
// enable drop and asynchronous reset, against a registered-read RAM model.
module tb_hub75_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [9:0]  read_addr;
    logic        read_en;
    logic [15:0] read_data_top;
    logic [15:0] read_data_bottom;
    logic        hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2;
    logic        hub75_clk, hub75_lat, hub75_oe_n;
    logic [3:0]  hub75_addr;
    logic        frame_done;

    logic        pattern_mode = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    int          rises, colour_bad, lat_at, enable_cyc, found, run_len;
    int          f1, f2, steps, bad_steps, distinct, addr_bad, idle_bad;
    logic        prev_hclk;
    logic [9:0]  last_a, exp_a;
    logic [15:0] tv, bv;
    logic [5:0]  exp_col;

    hub75_scanner dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .read_addr        (read_addr),
        .read_en          (read_en),
        .read_data_top    (read_data_top),
        .read_data_bottom (read_data_bottom),
        .hub75_r1         (hub75_r1),
        .hub75_g1         (hub75_g1),
        .hub75_b1         (hub75_b1),
        .hub75_r2         (hub75_r2),
        .hub75_g2         (hub75_g2),
        .hub75_b2         (hub75_b2),
        .hub75_clk        (hub75_clk),
        .hub75_lat        (hub75_lat),
        .hub75_oe_n       (hub75_oe_n),
        .hub75_addr       (hub75_addr),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pat_top(input logic [9:0] a);
        logic [31:0] h;
        h = 32'(a) * 32'd2654435761;
        return h[23:8];
    endfunction

    function automatic logic [15:0] pat_bot(input logic [9:0] a);
        return ~pat_top(a ^ 10'h2AA);
    endfunction

    // Framebuffer model: one-cycle registered read
    always @(posedge clk) begin
        read_data_top    <= pattern_mode ? pat_top(read_addr) : 16'hFFFF;
        read_data_bottom <= pattern_mode ? pat_bot(read_addr) : 16'h0000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Length of the next oe_n-low run, starting with the current sample
    task automatic measure_oe(output int len);
        len = 0;
        for (int i = 0; i < 20000; i++) begin
            if (hub75_oe_n == 1'b0) break;
            @(negedge clk);
        end
        while (hub75_oe_n == 1'b0 && len < 5000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_frame(output int at, output int nsteps, output int nbad);
        logic [3:0] last;
        at = -1;
        nsteps = 0;
        nbad = 0;
        last = hub75_addr;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (hub75_addr !== last) begin
                nsteps++;
                if (hub75_addr !== 4'(last + 4'd1)) nbad++;
                last = hub75_addr;
            end
            if (frame_done) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_addr(input logic [9:0] a, output int hit);
        hit = 0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (read_en && read_addr == a) begin
                hit = 1;
                break;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({hub75_oe_n, hub75_lat, hub75_clk, hub75_addr, hub75_r1, hub75_g1, hub75_b1,
                   hub75_r2, hub75_g2, hub75_b2, read_en, read_addr, frame_done}),
              32'({1'b1, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0, 10'd0, 1'b0}));
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_hold", 32'({read_en, hub75_oe_n}), 32'(2'b01));

        // Shift: white top half, black bottom half
        enable = 1'b1;
        enable_cyc = cyc;
        rises = 0; colour_bad = 0; lat_at = 0; prev_hclk = 1'b0;
        for (int k = 1; k <= 400 && lat_at == 0; k++) begin
            @(negedge clk);
            if (hub75_clk && !prev_hclk) rises++;
            if (hub75_clk && {hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2} !== 6'b111000)
                colour_bad++;
            prev_hclk = hub75_clk;
            if (hub75_lat) lat_at = k;
        end
        check("shift_rises", 32'(rises), 32'd64);
        check("shift_colour", 32'(colour_bad), 32'd0);
        check("latch_cycle", 32'(lat_at), 32'd131);
        @(negedge clk);
        check("latch_width_oe_on", 32'({hub75_lat, hub75_oe_n}), 32'd0);

        // BCM weights across all planes of row 0
        for (int p = 0; p < 5; p++) begin
            measure_oe(run_len);
            check($sformatf("bcm_plane%0d", p), 32'(run_len), 32'd32 << p);
            check($sformatf("bcm_addr%0d", p), 32'(hub75_addr), 32'd0);
        end

        // Frame cadence over two frames
        wait_frame(f1, steps, bad_steps);
        check("frame1_time", 32'(f1 - enable_cyc), 32'd26353);
        check("frame1_addr_steps", 32'(steps), 32'd15);
        check("frame1_addr_order", 32'(bad_steps), 32'd0);
        pattern_mode = 1'b1;
        @(negedge clk);
        check("frame_done_width", 32'(frame_done), 32'd0);
        wait_frame(f2, steps, bad_steps);
        check("frame_period", 32'(f2 - f1), 32'd26352);
        check("frame2_addr_steps", 32'(steps), 32'd16);
        check("frame2_addr_order", 32'(bad_steps), 32'd0);

        // Address sequence and colour pickup for row 3, plane 0
        wait_addr(10'd192, found);
        check("row3_start", 32'(found), 32'd1);
        last_a = 10'd192; distinct = 1; addr_bad = 0; rises = 0; colour_bad = 0;
        prev_hclk = hub75_clk;
        for (int i = 0; i < 200 && read_en; i++) begin
            @(negedge clk);
            if (!read_en) break;
            if (read_addr != last_a) begin
                if (read_addr != last_a + 10'd1) addr_bad++;
                distinct++;
                last_a = read_addr;
            end
            if (hub75_clk && !prev_hclk) begin
                exp_a = 10'(192 + rises);
                tv = pat_top(exp_a);
                bv = pat_bot(exp_a);
                exp_col = {tv[11], tv[6], tv[0], bv[11], bv[6], bv[0]};
                if ({hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2} !== exp_col)
                    colour_bad++;
                rises++;
            end
            prev_hclk = hub75_clk;
        end
        check("row3_addr_count", 32'(distinct), 32'd64);
        check("row3_addr_last", 32'(last_a), 32'd255);
        check("row3_addr_order", 32'(addr_bad), 32'd0);
        check("row3_rises", 32'(rises), 32'd64);
        check("row3_colour", 32'(colour_bad), 32'd0);
        measure_oe(run_len);
        check("row3_plane0_oe", 32'(run_len), 32'd32);

        // Enable drop partway through the row 5 shift
        wait_addr(10'd320, found);
        check("row5_start", 32'(found), 32'd1);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        measure_oe(run_len);
        check("drop_plane_completes", 32'(run_len), 32'd32);
        idle_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (!hub75_oe_n || read_en || hub75_lat || hub75_clk || frame_done) idle_bad++;
            @(negedge clk);
        end
        check("drop_idle", 32'(idle_bad), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("restart_addr", 32'({read_en, read_addr}), 32'({1'b1, 10'd0}));
        measure_oe(run_len);
        check("restart_plane0", 32'(run_len), 32'd32);

        // Asynchronous reset during DISPLAY
        measure_oe(run_len);
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!hub75_oe_n) begin
                found = 1;
                break;
            end
        end
        check("display_reached", 32'(found), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset",
              32'({hub75_oe_n, hub75_lat, read_en, hub75_clk, hub75_addr, frame_done}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_restart_addr", 32'({read_en, read_addr}), 32'({1'b1, 10'd0}));
        measure_oe(run_len);
        check("reset_restart_plane0", 32'(run_len), 32'd32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hub75_scanner.md
HUB75_SCANNER -- requirements
Module: hub75_scanner

Interface
REQ-001 SHALL have parameter PANEL_WIDTH, default 64, meaning pixels per shifted row.
REQ-002 SHALL have parameter HALF_ROWS, default 16, meaning scan rows per frame, each pairing top and bottom halves.
REQ-003 SHALL have parameter PLANES, default 5, meaning BCM bit planes per colour channel.
REQ-004 SHALL have parameter BASE_CYCLES, default 32, meaning OE-on cycles for plane 0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1 bit: run scanning.
REQ-008 SHALL have port read_addr, output, 10 bits: framebuffer read address {row[3:0], col[5:0]}.
REQ-009 SHALL have port read_en, output, 1 bit: framebuffer read enable.
REQ-010 SHALL have port read_data_top, input, 16 bits: RGB565 pixel for the top half, valid 1 cycle after address.
REQ-011 SHALL have port read_data_bottom, input, 16 bits: RGB565 pixel for the bottom half, same timing as read_data_top.
REQ-012 SHALL have ports hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2, output, 1 bit each: panel colour data.
REQ-013 SHALL have port hub75_clk, output, 1 bit: panel shift clock.
REQ-014 SHALL have port hub75_lat, output, 1 bit: panel latch.
REQ-015 SHALL have port hub75_oe_n, output, 1 bit: panel output enable, active-low.
REQ-016 SHALL have port hub75_addr, output, 4 bits: panel row select.
REQ-017 SHALL have port frame_done, output, 1 bit: 1-cycle pulse at frame end, used by the system to drive buffer_toggle.

Function
REQ-018 SHALL implement the states IDLE, PREFETCH, SHIFT_LO, SHIFT_HI, BLANK, LATCH and DISPLAY.
REQ-019 SHALL drive all outputs from registers, with no combinational paths from inputs to outputs.
REQ-020 SHALL make these IDLE transitions: enable=1 -> PREFETCH with row=0, plane=0, col=0; otherwise stay in IDLE.
REQ-021 SHALL in PREFETCH, for 1 cycle, drive read_en=1 and read_addr={row,0}, then go to SHIFT_LO.
REQ-022 SHALL in SHIFT_LO drive hub75_clk=0 and register the colour outputs from the RAM data: r = data[11+plane], g = data[6+plane], b = data[0+plane], using top data for r1/g1/b1 and bottom data for r2/g2/b2.
REQ-023 SHALL in SHIFT_HI drive hub75_clk=1; if col<PANEL_WIDTH-1, issue read_addr={row,col+1}, increment col and go to SHIFT_LO; otherwise go to BLANK.
REQ-024 SHALL produce exactly PANEL_WIDTH rising edges of hub75_clk per plane, with colour data stable across each rising edge.
REQ-025 SHALL hold hub75_oe_n=1 in every state except DISPLAY.
REQ-026 SHALL in BLANK, for 1 cycle, load hub75_addr with row.
REQ-027 SHALL in LATCH, for 1 cycle, drive hub75_lat=1; hub75_lat SHALL be 0 in all other states.
REQ-028 SHALL in DISPLAY drive hub75_oe_n=0 for exactly BASE_CYCLES << plane cycles, using a 16-bit down-counter.
REQ-029 SHALL at the end of DISPLAY, when plane<PLANES-1, increment plane.
REQ-030 SHALL at the end of DISPLAY, when plane=PLANES-1, set plane=0 and increment row.
REQ-031 SHALL wrap row from HALF_ROWS-1 to 0 and pulse frame_done=1 for exactly 1 cycle on that wrap.
REQ-032 SHALL sample enable only in IDLE and at the end of DISPLAY; enable=0 at end of DISPLAY -> IDLE, with row and plane cleared and no frame_done unless the wrap coincides.
REQ-033 SHALL keep read_en=1 in PREFETCH, SHIFT_LO and SHIFT_HI, and 0 elsewhere.
REQ-034 SHALL take 131 + (BASE_CYCLES << p) cycles per plane p, and 26352 cycles per frame at the defaults.

Reset
REQ-035 SHALL on reset_n=0, immediately and without a clock edge, force IDLE with row, plane and col at 0.
REQ-036 SHALL on reset_n=0 force hub75_oe_n=1, hub75_lat=0, hub75_clk=0, hub75_addr=0, all colour outputs 0, read_en=0, read_addr=0 and frame_done=0.
REQ-037 SHALL handle reset asserted mid-DISPLAY or mid-SHIFT by blanking the panel (oe_n=1) in the same instant and then resuming from row 0, plane 0.

Verification
REQ-038 SHALL be covered by scenario Shift: RAM model with top=16'hFFFF and bottom=16'h0000, enable=1 -> 64 hub75_clk rises, r1=g1=b1=1, r2=g2=b2=0, then lat pulse, then oe_n low for 32 cycles.
REQ-039 SHALL be covered by scenario BCM: count oe_n-low cycles per plane for row 0 -> 32, 64, 128, 256, 512; hub75_addr stays 0 throughout.
REQ-040 SHALL be covered by scenario Address: check read_addr sequence for row 3 -> 192..255 in order, each followed 1 cycle later by the matching data on the colour outputs.
REQ-041 SHALL be covered by scenario Frame: free-run for two frames -> frame_done pulses exactly every 26352 cycles; hub75_addr steps 0..15 and wraps to 0.
REQ-042 SHALL be covered by scenario Enable drop: deassert enable mid-SHIFT of row 5 -> row 5 plane completes, then IDLE with oe_n=1; re-enabling restarts at read_addr 0.
REQ-043 SHALL be covered by scenario Reset: assert reset_n=0 mid-DISPLAY -> oe_n=1 and lat=0 with no clock edge; after release and enable=1, first read_addr=0.
